// File: rtl/addsub_bist_pkg.sv
// Shared types and the golden model for the adder/subtractor BIST driver.
package addsub_bist_pkg;

  // Sweep controller states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    APPLY = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } bist_state_t;

  // Default operand width and the matching exhaustive vector count {M,A,B}
  localparam int DEF_WIDTH = 4;
  localparam int NVEC      = 2**(2*DEF_WIDTH+1);

  // Widest operand the golden function can model; callers pass their real width
  localparam int MAX_W = 16;

  // Ripple model of A + (B ^ {w{m}}) + m over the low w bits.
  // Result layout: {C_exp[MAX_W-1:0], S_exp[MAX_W-1:0], V_exp}; bits at or
  // above w in C_exp/S_exp are zero. Requires 2 <= w <= MAX_W.
  function automatic logic [2*MAX_W:0] golden(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input logic             m,
                                               input int               w);
    logic [MAX_W:0]   carry;
    logic [MAX_W-1:0] s;
    logic [MAX_W-1:0] co;
    logic             bb;
    logic             v;
    carry    = '0;
    carry[0] = m;
    s        = '0;
    co       = '0;
    bb       = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        bb         = b[i] ^ m;
        s[i]       = a[i] ^ bb ^ carry[i];
        carry[i+1] = (a[i] & bb) | (a[i] & carry[i]) | (bb & carry[i]);
        co[i]      = carry[i+1];
      end
    end
    v = co[w-1] ^ co[w-2];
    return {co, s, v};
  endfunction

endpackage

// File: rtl/addsub_bist_driver_if.sv
// Bus between the BIST driver and the adder/subtractor under test.
// The driver (master) owns A/B/M; the adder/subtractor (slave) returns S/C/Cout/V.
interface addsub_bist_driver_if
  import addsub_bist_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             M;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] C;
  logic             Cout;
  logic             V;

  modport master (
    output A, B, M,
    input  S, C, Cout, V
  );

  modport slave (
    input  A, B, M,
    output S, C, Cout, V
  );

endinterface

// File: rtl/addsub_ref_model.sv
// Combinational golden model of the WIDTH-bit adder/subtractor.
module addsub_ref_model
  import addsub_bist_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_m,
  output logic [WIDTH-1:0] o_s,
  output logic [WIDTH-1:0] o_c,
  output logic             o_cout,
  output logic             o_v
);

  logic [MAX_W-1:0] w_a;
  logic [MAX_W-1:0] w_b;
  logic [2*MAX_W:0] w_res;
  logic             w_unused_res;

  assign w_a   = MAX_W'(i_a);
  assign w_b   = MAX_W'(i_b);
  assign w_res = golden(w_a, w_b, i_m, WIDTH);

  assign o_v    = w_res[0];
  assign o_s    = w_res[WIDTH:1];
  assign o_c    = w_res[MAX_W+1 +: WIDTH];
  assign o_cout = w_res[MAX_W+WIDTH];

  // Upper bits of the wide result are always zero for WIDTH < MAX_W
  assign w_unused_res = ^w_res;

endmodule

// File: rtl/addsub_bist_driver.sv
// Exhaustive stimulus generator and response checker for a WIDTH-bit
// adder/subtractor: sweeps every {M,A,B}, compares against the golden model,
// counts failing vectors and remembers the first one.
module addsub_bist_driver
  import addsub_bist_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  addsub_bist_driver_if.master dut_bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count,
  output logic [2*WIDTH:0]     first_fail,
  output bist_state_t          o_dbg_state
);

  localparam int IW = 2*WIDTH + 1;                     // vector index width
  localparam int EW = 2*WIDTH + 2;                     // holds the full vector count
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IW-1:0] LAST_IDX = '1;

  // Handshake: start is a level sampled only in IDLE or DONE; the accepting
  // edge raises busy and clears done/pass/err_count/first_fail. busy stays
  // high for (SETTLE+2)*2^IW cycles, then done rises together with pass and
  // both hold until the next accepted start. start while busy is ignored.

  bist_state_t      r_state;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_settle;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_m;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [EW-1:0]    r_err;
  logic [IW-1:0]    r_first;

  logic [WIDTH-1:0] w_s_exp;
  logic [WIDTH-1:0] w_c_exp;
  logic             w_cout_exp;
  logic             w_v_exp;
  logic             w_mismatch;

  addsub_ref_model #(.WIDTH(WIDTH)) u_ref (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_m    (r_m),
    .o_s    (w_s_exp),
    .o_c    (w_c_exp),
    .o_cout (w_cout_exp),
    .o_v    (w_v_exp)
  );

  // One vector is one error no matter how many response fields disagree
  assign w_mismatch = (dut_bus.S    != w_s_exp)    |
                      (dut_bus.C    != w_c_exp)    |
                      (dut_bus.Cout != w_cout_exp) |
                      (dut_bus.V    != w_v_exp);

  // Sweep controller: vector sequencing, settle timing and error bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_settle <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_err    <= '0;
      r_first  <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_err   <= '0;
            r_first <= '0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= APPLY;
          end
        end
        APPLY: begin
          {r_m, r_a, r_b} <= r_idx;
          r_settle        <= CW'(SETTLE - 1);
          r_state         <= WAIT;
        end
        WAIT: begin
          if (r_settle == '0) begin
            r_state <= CHECK;
          end else begin
            r_settle <= r_settle - CW'(1);
          end
        end
        CHECK: begin
          if (w_mismatch) begin
            r_err <= r_err + EW'(1);
            if (r_err == '0) begin
              r_first <= r_idx;
            end
          end
          if (r_idx == LAST_IDX) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_err == '0) && !w_mismatch;
            r_state <= DONE;
          end else begin
            r_idx   <= r_idx + IW'(1);
            r_state <= APPLY;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dut_bus.A   = r_a;
  assign dut_bus.B   = r_b;
  assign dut_bus.M   = r_m;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign err_count   = r_err;
  assign first_fail  = r_first;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_addsub_bist_driver.sv
// Directed bench for addsub_bist_driver: a behavioural 4-bit adder/subtractor
// with optional faults and a 2-cycle output delay sits on each driver's bus.
module tb_addsub_bist_driver;
  import addsub_bist_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus controls ----------------
  logic start1;
  logic start3;
  logic tsel;      // 0: SETTLE=1 instance, 1: SETTLE=3 instance
  int   fault;     // 0 none, 1 S[0] stuck at 0, 2 V inverted (instance 1 only)
  logic del1;      // instance 1 adder uses the 2-cycle delayed outputs

  int n_checks;
  int n_fail;

  // ---------------- DUT instances ----------------
  addsub_bist_driver_if #(.WIDTH(4)) if1 ();
  addsub_bist_driver_if #(.WIDTH(4)) if3 ();

  logic        busy1, done1, pass1;
  logic [9:0]  err1;
  logic [8:0]  ff1;
  bist_state_t st1;
  logic        busy3, done3, pass3;
  logic [9:0]  err3;
  logic [8:0]  ff3;
  bist_state_t st3;

  addsub_bist_driver #(.WIDTH(4), .SETTLE(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start1),
    .dut_bus     (if1),
    .busy        (busy1),
    .done        (done1),
    .pass        (pass1),
    .err_count   (err1),
    .first_fail  (ff1),
    .o_dbg_state (st1)
  );

  addsub_bist_driver #(.WIDTH(4), .SETTLE(3)) dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start3),
    .dut_bus     (if3),
    .busy        (busy3),
    .done        (done3),
    .pass        (pass3),
    .err_count   (err3),
    .first_fail  (ff3),
    .o_dbg_state (st3)
  );

  // ---------------- behavioural adder/subtractor ----------------
  // Result layout {S[3:0], C[3:0], Cout, V}, built from integer sums and the
  // sign rule for overflow.
  function automatic logic [9:0] model(input logic [3:0] a, input logic [3:0] b, input logic m);
    int         ai;
    int         bi;
    int         ci;
    int         mask;
    logic [3:0] c;
    logic [3:0] sv;
    logic       v;
    ai = int'(a);
    bi = m ? (15 - int'(b)) : int'(b);
    ci = m ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      mask = (1 << (i + 1)) - 1;
      c[i] = (((ai & mask) + (bi & mask) + ci) >> (i + 1)) != 0;
    end
    sv = 4'((ai + bi + ci) & 15);
    if (m) v = (a[3] != b[3]) && (sv[3] != a[3]);
    else   v = (a[3] == b[3]) && (sv[3] != a[3]);
    return {sv, c, c[3], v};
  endfunction

  logic [9:0] m1_c, m1_p1, m1_p2, m1_sel;
  logic [9:0] m3_c, m3_p1, m3_p2;

  always_comb m1_c = model(if1.A, if1.B, if1.M);
  always_comb m3_c = model(if3.A, if3.B, if3.M);

  always @(posedge clk) begin
    m1_p1 <= m1_c;
    m1_p2 <= m1_p1;
    m3_p1 <= m3_c;
    m3_p2 <= m3_p1;
  end

  assign m1_sel   = del1 ? m1_p2 : m1_c;
  assign if1.S    = (fault == 1) ? {m1_sel[9:7], 1'b0} : m1_sel[9:6];
  assign if1.C    = m1_sel[5:2];
  assign if1.Cout = m1_sel[1];
  assign if1.V    = (fault == 2) ? ~m1_sel[0] : m1_sel[0];

  assign if3.S    = m3_p2[9:6];
  assign if3.C    = m3_p2[5:2];
  assign if3.Cout = m3_p2[1];
  assign if3.V    = m3_p2[0];

  // ---------------- observed-signal muxes ----------------
  logic        cur_busy, cur_done, cur_pass;
  logic [9:0]  cur_err;
  logic [8:0]  cur_ff;
  logic [8:0]  cur_vec;
  bist_state_t cur_state;

  assign cur_busy  = tsel ? busy3 : busy1;
  assign cur_done  = tsel ? done3 : done1;
  assign cur_pass  = tsel ? pass3 : pass1;
  assign cur_err   = tsel ? err3  : err1;
  assign cur_ff    = tsel ? ff3   : ff1;
  assign cur_state = tsel ? st3   : st1;
  assign cur_vec   = tsel ? {if3.M, if3.A, if3.B} : {if1.M, if1.A, if1.B};

  // ---------------- driver tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    if (tsel) start3 = v;
    else      start1 = v;
  endtask

  // Pulse start, then follow the sweep to done. cycles counts edges after the
  // accepting edge (-1 on timeout). Vector k is applied on edge 1+k*per.
  task automatic run_sweep(input int per, input int restart_at,
                           output int cycles, output logic order_ok,
                           output logic busy_ok, output logic clear_ok);
    int   c;
    logic seen;
    @(negedge clk);
    drive_start(1'b1);
    @(posedge clk);
    #1;
    drive_start(1'b0);
    clear_ok = (cur_busy === 1'b1) && (cur_done === 1'b0) && (cur_pass === 1'b0) &&
               (cur_err === 10'd0) && (cur_ff === 9'd0);
    order_ok = 1'b1;
    busy_ok  = 1'b1;
    seen     = 1'b0;
    c        = 0;
    while (!seen && c < 4000) begin
      @(posedge clk);
      c++;
      #1;
      if (c == restart_at)          drive_start(1'b1);
      else if (c == restart_at + 1) drive_start(1'b0);
      if (cur_done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (cur_busy !== 1'b1) busy_ok = 1'b0;
        if (cur_vec !== 9'((c - 1) / per)) order_ok = 1'b0;
      end
    end
    cycles = seen ? c : -1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  int   cyc;
  logic ord_ok, bsy_ok, clr_ok;
  int   k;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start1   = 1'b0;
    start3   = 1'b0;
    tsel     = 1'b0;
    fault    = 0;
    del1     = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_vec",   32'(cur_vec), 0);
    chk("rst_busy",  32'(busy1), 0);
    chk("rst_done",  32'(done1), 0);
    chk("rst_pass",  32'(pass1), 0);
    chk("rst_err",   32'(err1), 0);
    chk("rst_ff",    32'(ff1), 0);
    chk("rst_state", 32'(st1), 32'(IDLE));
    chk("rst_state3", 32'(st3), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: good adder, SETTLE=1
    run_sweep(3, -1, cyc, ord_ok, bsy_ok, clr_ok);
    chk("t1_cycles", 32'(cyc), 1536);
    chk("t1_order",  32'(ord_ok), 1);
    chk("t1_busy",   32'(bsy_ok), 1);
    chk("t1_clear",  32'(clr_ok), 1);
    chk("t1_pass",   32'(cur_pass), 1);
    chk("t1_err",    32'(cur_err), 0);
    chk("t1_ff",     32'(cur_ff), 0);
    chk("t1_busy_end", 32'(cur_busy), 0);
    chk("t1_state",  32'(cur_state), 32'(DONE));
    repeat (2) @(posedge clk);
    #1;
    chk("t1_done_sticky", 32'(cur_done), 1);

    // 2: S[0] stuck at 0 -> fails whenever A0^B0 = 1
    fault = 1;
    run_sweep(3, -1, cyc, ord_ok, bsy_ok, clr_ok);
    chk("t2_cycles", 32'(cyc), 1536);
    chk("t2_clear",  32'(clr_ok), 1);
    chk("t2_err",    32'(cur_err), 256);
    chk("t2_ff",     32'(cur_ff), 1);
    chk("t2_pass",   32'(cur_pass), 0);

    // 3: V inverted -> every vector fails, first is vector 0
    fault = 2;
    run_sweep(3, -1, cyc, ord_ok, bsy_ok, clr_ok);
    chk("t3_clear",  32'(clr_ok), 1);
    chk("t3_err",    32'(cur_err), 512);
    chk("t3_ff",     32'(cur_ff), 0);
    chk("t3_pass",   32'(cur_pass), 0);

    // 4: start pulsed 100 cycles into the sweep is ignored
    fault = 0;
    run_sweep(3, 100, cyc, ord_ok, bsy_ok, clr_ok);
    chk("t4_cycles", 32'(cyc), 1536);
    chk("t4_order",  32'(ord_ok), 1);
    chk("t4_busy",   32'(bsy_ok), 1);
    chk("t4_pass",   32'(cur_pass), 1);
    chk("t4_err",    32'(cur_err), 0);

    // 5: reset at idx=37 during a faulty sweep, then a clean sweep
    fault = 1;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    k = 0;
    while (cur_vec !== 9'd37 && k < 1000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("t5_reach37", 32'(cur_vec), 37);
    chk("t5_err_pre", 32'(cur_err), 18);
    chk("t5_ff_pre",  32'(cur_ff), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_vec",   32'(cur_vec), 0);
    chk("t5_rst_busy",  32'(cur_busy), 0);
    chk("t5_rst_done",  32'(cur_done), 0);
    chk("t5_rst_pass",  32'(cur_pass), 0);
    chk("t5_rst_err",   32'(cur_err), 0);
    chk("t5_rst_ff",    32'(cur_ff), 0);
    chk("t5_rst_state", 32'(cur_state), 32'(IDLE));
    fault = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_idle", 32'(cur_state), 32'(IDLE));
    run_sweep(3, -1, cyc, ord_ok, bsy_ok, clr_ok);
    chk("t5_cycles", 32'(cyc), 1536);
    chk("t5_order",  32'(ord_ok), 1);
    chk("t5_pass",   32'(cur_pass), 1);
    chk("t5_err",    32'(cur_err), 0);

    // 6a: adder with 2-cycle output delay, SETTLE=1 -> fails
    del1 = 1'b1;
    run_sweep(3, -1, cyc, ord_ok, bsy_ok, clr_ok);
    chk("t6a_cycles", 32'(cyc), 1536);
    chk("t6a_pass",   32'(cur_pass), 0);
    chk("t6a_err_nz", 32'(cur_err != 10'd0), 1);
    del1 = 1'b0;

    // 6b: same delayed adder, SETTLE=3 -> passes in 512*5 cycles
    tsel = 1'b1;
    @(negedge clk);
    run_sweep(5, -1, cyc, ord_ok, bsy_ok, clr_ok);
    chk("t6b_cycles", 32'(cyc), 2560);
    chk("t6b_order",  32'(ord_ok), 1);
    chk("t6b_busy",   32'(bsy_ok), 1);
    chk("t6b_pass",   32'(cur_pass), 1);
    chk("t6b_err",    32'(cur_err), 0);
    chk("t6b_ff",     32'(cur_ff), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
